// File: rtl/fasttwosum_pkg.sv
// Shared types and width helpers for the FastTwoSum group accumulator.
package fasttwosum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } grp_state_e;

   // Enough headroom to sum max_vecs full-scale tree results without overflow.
   function automatic int unsigned acc_width(input int unsigned sum_w,
                                             input int unsigned max_vecs);
      return sum_w + $clog2(max_vecs);
   endfunction

endpackage

// File: rtl/fasttwosum_valid_delay.sv
// 1-bit valid shift register matching the adder tree pipeline depth.
module fasttwosum_valid_delay #(
   parameter int unsigned DEPTH = 6
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic in_i,
   output logic out_o
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   if (DEPTH == 1) begin : g_one
      always_comb sr_d = in_i;
   end else begin : g_multi
      always_comb sr_d = {sr_q[DEPTH-2:0], in_i};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) sr_q <= '0;
      else         sr_q <= sr_d;
   end

   assign out_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fasttwosum_group_accumulator.sv
// Sums groups of consecutive FastTwoSum tree results and presents each total
// on a valid/ready port, tracking in-flight vectors against the tree latency.
module fasttwosum_group_accumulator
   import fasttwosum_pkg::*;
#(
   parameter int unsigned SUM_WIDTH    = 18,
   parameter int unsigned TREE_LATENCY = 6,
   parameter int unsigned MAX_VECS     = 64,
   parameter int unsigned LEN_WIDTH    = $clog2(MAX_VECS + 1),
   parameter int unsigned ACC_WIDTH    = acc_width(SUM_WIDTH, MAX_VECS)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [LEN_WIDTH-1:0] cfg_len_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [SUM_WIDTH-1:0] tree_sum_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [ACC_WIDTH-1:0] out_sum_o,
   output logic                 busy_o
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_VECS);

   grp_state_e           state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] iss_cnt_q, iss_cnt_d;
   logic [LEN_WIDTH-1:0] ret_cnt_q, ret_cnt_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
   logic                 out_valid_q, out_valid_d;

   logic [LEN_WIDTH-1:0] len_res;
   logic [ACC_WIDTH-1:0] sum_ext;
   logic [ACC_WIDTH-1:0] acc_plus;
   logic                 accept;
   logic                 ret;

   fasttwosum_valid_delay #(
      .DEPTH (TREE_LATENCY)
   ) u_valid_delay (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .in_i   (accept),
      .out_o  (ret)
   );

   assign in_ready_o = (state_q == IDLE) || (state_q == ISSUE);
   assign accept     = in_valid_i && in_ready_o;
   assign sum_ext    = {{(ACC_WIDTH - SUM_WIDTH){tree_sum_i[SUM_WIDTH-1]}}, tree_sum_i};
   assign acc_plus   = acc_q + sum_ext;

   always_comb begin
      len_res = cfg_len_i;
      if (cfg_len_i == '0)          len_res = LEN_ONE;
      else if (cfg_len_i > LEN_MAX) len_res = LEN_MAX;
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      iss_cnt_d   = iss_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      acc_d       = acc_q;
      out_sum_d   = out_sum_q;
      out_valid_d = out_valid_q;

      // Issue and return overlap, so both counters may step in the same cycle.
      if (ret) begin
         acc_d     = acc_plus;
         ret_cnt_d = ret_cnt_q + LEN_ONE;
      end
      if (accept) iss_cnt_d = iss_cnt_q + LEN_ONE;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               len_d   = len_res;
               state_d = (len_res == LEN_ONE) ? DRAIN : ISSUE;
            end
         end
         ISSUE: begin
            if (accept && (iss_cnt_q + LEN_ONE == len_q)) state_d = DRAIN;
         end
         DRAIN: begin
            if (ret && (ret_cnt_q + LEN_ONE == len_q)) begin
               state_d     = HOLD;
               out_sum_d   = acc_plus;
               out_valid_d = 1'b1;
            end
         end
         HOLD: begin
            if (out_ready_i) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               acc_d       = '0;
               iss_cnt_d   = '0;
               ret_cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         len_q       <= '0;
         iss_cnt_q   <= '0;
         ret_cnt_q   <= '0;
         acc_q       <= '0;
         out_sum_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         iss_cnt_q   <= iss_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         acc_q       <= acc_d;
         out_sum_q   <= out_sum_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_sum_o   = out_sum_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_fasttwosum_group_accumulator.sv
// Directed bench: models the adder tree as a fixed-latency pipeline feeding the DUT.
module tb_fasttwosum_group_accumulator;

   localparam int unsigned SW = 18;
   localparam int unsigned TL = 6;
   localparam int unsigned MV = 64;
   localparam int unsigned LW = 7;
   localparam int unsigned AW = 24;
   localparam logic [SW-1:0] JUNK = 18'h15555;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [LW-1:0] cfg_len;
   logic          in_valid;
   logic          in_ready;
   logic [SW-1:0] tree_sum;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_sum;
   logic          busy;

   logic [SW-1:0] vec_val;
   logic [SW-1:0] pipe_d [TL];
   logic          pipe_v [TL];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fasttwosum_group_accumulator #(
      .SUM_WIDTH    (SW),
      .TREE_LATENCY (TL),
      .MAX_VECS     (MV)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cfg_len_i   (cfg_len),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .tree_sum_i  (tree_sum),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_sum_o   (out_sum),
      .busy_o      (busy)
   );

   // Tree model: result of an accepted vector appears TL edges after its sample edge;
   // junk is driven otherwise so a mistimed accumulation corrupts the total.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < TL; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_d[i] <= '0;
         end
      end else begin
         pipe_v[0] <= in_valid && in_ready;
         pipe_d[0] <= vec_val;
         for (int i = 1; i < TL; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   assign tree_sum = pipe_v[TL-1] ? pipe_d[TL-1] : JUNK;

   task automatic send(input logic [SW-1:0] v, input logic [LW-1:0] len);
      in_valid = 1'b1;
      cfg_len  = len;
      vec_val  = v;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int cyc = 0;
      while (!out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %0h expected 0", out_sum); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_len4_latency();
      send(SW'(10), 7'd4);
      send(SW'(-3), 7'd4);
      send(SW'(7), 7'd4);
      send(SW'(1), 7'd4);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len4_ready_drain: got %b expected 0", in_ready); end
      repeat (TL - 1) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len4_valid_early: got %b expected 0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len4_valid_latency: got %b expected 1", out_valid); end
      checks++; if (out_sum !== AW'(15)) begin errors++; $display("FAIL len4_sum: got %0h expected %0h", out_sum, AW'(15)); end
      handshake();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len4_valid_drop: got %b expected 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len4_busy_idle: got %b expected 0", busy); end
   endtask

   task automatic test_len1_min();
      send(18'h20000, 7'd1);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len1_direct_drain: got %b expected 0", in_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL len1_busy: got %b expected 1", busy); end
      wait_out();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len1_valid: got %b expected 1", out_valid); end
      checks++; if (out_sum !== 24'hFE0000) begin errors++; $display("FAIL len1_sum: got %0h expected fe0000", out_sum); end
      handshake();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL len1_back_idle: got %b expected 1", in_ready); end
   endtask

   task automatic test_len_max();
      for (int i = 0; i < MV; i++) send(18'h1FFFF, 7'd64);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lenmax_ready: got %b expected 0", in_ready); end
      wait_out();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lenmax_valid: got %b expected 1", out_valid); end
      checks++; if (out_sum !== 24'h7FFFC0) begin errors++; $display("FAIL lenmax_sum: got %0h expected 7fffc0", out_sum); end
      handshake();
   endtask

   task automatic test_len_clamp();
      for (int i = 0; i < MV - 1; i++) send(SW'(1), 7'd127);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clamp_still_issue: got %b expected 1", in_ready); end
      send(SW'(1), 7'd127);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clamp_closed: got %b expected 0", in_ready); end
      wait_out();
      checks++; if (out_sum !== AW'(64)) begin errors++; $display("FAIL clamp_sum: got %0h expected 40", out_sum); end
      handshake();
   endtask

   task automatic test_backpressure();
      send(SW'(100), 7'd2);
      send(SW'(200), 7'd2);
      wait_out();
      in_valid = 1'b1;
      cfg_len  = 7'd1;
      vec_val  = SW'(999);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++; if (out_sum !== AW'(300) || out_valid !== 1'b1) begin errors++; $display("FAIL hold_stable[%0d]: got %0h/%b expected 12c/1", i, out_sum, out_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
      end
      in_valid = 1'b0;
      handshake();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b expected 0", out_valid); end
      send(SW'(7), 7'd1);
      wait_out();
      checks++; if (out_sum !== AW'(7)) begin errors++; $display("FAIL hold_ignored_input: got %0h expected 7", out_sum); end
      handshake();
   endtask

   task automatic test_mid_reset();
      send(SW'(1), 7'd8);
      send(SW'(2), 7'd8);
      send(SW'(3), 7'd8);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_sum !== '0) begin errors++; $display("FAIL mrst_out_sum: got %0h expected 0", out_sum); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b expected 0", busy); end
      repeat (TL + 2) @(negedge clk);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mrst_no_stale: got %b/%b expected 0/0", out_valid, busy); end
      send(SW'(5), 7'd2);
      send(SW'(5), 7'd2);
      wait_out();
      checks++; if (out_sum !== AW'(10)) begin errors++; $display("FAIL mrst_next_sum: got %0h expected a", out_sum); end
      handshake();
   endtask

   task automatic test_len_latch();
      send(SW'(42), 7'd0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len0_as_one: got %b expected 0", in_ready); end
      wait_out();
      checks++; if (out_sum !== AW'(42)) begin errors++; $display("FAIL len0_sum: got %0h expected 2a", out_sum); end
      handshake();
      send(SW'(1), 7'd3);
      send(SW'(2), 7'd9);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL latch_mid_issue: got %b expected 1", in_ready); end
      send(SW'(3), 7'd9);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL latch_closed_at3: got %b expected 0", in_ready); end
      wait_out();
      checks++; if (out_sum !== AW'(6)) begin errors++; $display("FAIL latch_sum: got %0h expected 6", out_sum); end
      handshake();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      cfg_len   = '0;
      vec_val   = '0;
      @(negedge clk);
      test_reset();
      test_len4_latency();
      test_len1_min();
      test_len_max();
      test_len_clamp();
      test_backpressure();
      test_mid_reset();
      test_len_latch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
